// File: rtl/dptr_pkg.sv
// Shared types and constants for the DPTR multi-cycle control path:
// sequencer state encoding, primary opcode values, opcode classes and
// ALU operation encodings.
package dptr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LW   = 3'd1,
        CLS_SW   = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_ADDI = 3'd4,
        CLS_ILL  = 3'd5
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operation used while an instruction of the given class executes.
    function automatic logic [1:0] aluOpFor(input op_class_t cls);
        logic [1:0] op;
        case (cls)
            CLS_R:   op = ALUOP_FUNCT;
            CLS_BEQ: op = ALUOP_SUB;
            default: op = ALUOP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier: maps IR[31:26] to an instruction class.
// Anything not recognised is classed as illegal.
module op_class_decode
    import dptr_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_t  class_o
);

    // Match the primary opcode against the supported instruction set.
    always_comb begin
        class_o = CLS_ILL;
        case (opcode_i)
            OP_RTYPE: class_o = CLS_R;
            OP_LW:    class_o = CLS_LW;
            OP_SW:    class_o = CLS_SW;
            OP_BEQ:   class_o = CLS_BEQ;
            OP_ADDI:  class_o = CLS_ADDI;
            default:  class_o = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the DPTR datapath. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables.
// Optional feature: define MULTICYCLE_CTRL_TRAP_EN to send illegal opcodes
// to a sticky TRAP state; otherwise they retire as NOPs in DECODE.
module multicycle_ctrl
    import dptr_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       iOrD_o,
    output logic       memToRead_o,
    output logic       memToWrite_o,
    output logic       irWrite_o,
    output logic       pcWrite_o,
    output logic       pcSrc_o,
    output logic       aluSrc_o,
    output logic [1:0] aluOp_o,
    output logic       regDst_o,
    output logic       memToReg_o,
    output logic       regWrite_o,
    output logic       retire_o,
    output logic       trap_o,
    output logic [2:0] state_o
);

    state_t    state_q, state_d;
    op_class_t class_q, class_d;
    op_class_t decClass;
    state_t    returnState;

    op_class_decode uDecode (
        .opcode_i (opcode_i),
        .class_o  (decClass)
    );

    assign state_o     = state_q;
    assign returnState = run_i ? ST_FETCH : ST_IDLE;

    // State and latched instruction class; reset aborts any instruction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            class_q <= CLS_R;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    // Next-state selection and datapath strobes for the current state.
    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        iOrD_o       = 1'b0;
        memToRead_o  = 1'b0;
        memToWrite_o = 1'b0;
        irWrite_o    = 1'b0;
        pcWrite_o    = 1'b0;
        pcSrc_o      = 1'b0;
        aluSrc_o     = 1'b0;
        aluOp_o      = ALUOP_ADD;
        regDst_o     = 1'b0;
        memToReg_o   = 1'b0;
        regWrite_o   = 1'b0;
        retire_o     = 1'b0;
        trap_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                memToRead_o = 1'b1;
                if (mem_ready_i) begin
                    irWrite_o = 1'b1;
                    pcWrite_o = 1'b1;
                    state_d   = ST_DECODE;
                end
            end

            ST_DECODE: begin
                class_d = decClass;
                if (decClass == CLS_ILL) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    retire_o = 1'b1;
                    state_d  = returnState;
`endif
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                aluOp_o  = aluOpFor(class_q);
                aluSrc_o = (class_q == CLS_LW) || (class_q == CLS_SW) ||
                           (class_q == CLS_ADDI);
                case (class_q)
                    CLS_BEQ: begin
                        pcWrite_o = zero_i;
                        pcSrc_o   = 1'b1;
                        retire_o  = 1'b1;
                        state_d   = returnState;
                    end
                    CLS_R, CLS_ADDI: state_d = ST_WB;
                    CLS_LW, CLS_SW:  state_d = ST_MEM;
                    default:         state_d = returnState;
                endcase
            end

            ST_MEM: begin
                iOrD_o       = 1'b1;
                memToRead_o  = (class_q == CLS_LW);
                memToWrite_o = (class_q == CLS_SW);
                if (mem_ready_i) begin
                    if (class_q == CLS_SW) begin
                        retire_o = 1'b1;
                        state_d  = returnState;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end

            ST_WB: begin
                regWrite_o = 1'b1;
                retire_o   = 1'b1;
                regDst_o   = (class_q == CLS_R);
                memToReg_o = (class_q == CLS_LW);
                state_d    = returnState;
            end

            ST_TRAP: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                trap_o  = 1'b1;
                state_d = ST_TRAP;
`else
                state_d = ST_IDLE;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
